pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It merges stall requests from ID, EX and MEM into the 6-bit `stall` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It runs the multi-cycle divide wait with a timeout, and drives pipeline flush plus the redirect PC on exceptions and `eret`. It also keeps a saturating count of cycles in which the PC is stalled.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage MIPS core.
// Merges ID/EX/MEM stall requests into the 6-bit stall vector, supervises
// the multi-cycle divide wait (with timeout), issues flush plus redirect PC
// on exceptions and eret, and counts PC-stalled cycles (saturating).
//
// Handshake note: there is no valid/ready pair here.  div_start_i is a
// one-cycle request that is only honoured in RUN; div_ready_i is sampled
// only in DIV_WAIT and releases EX in the same cycle it is seen.
module pipe_ctrl #(
    parameter int          DIV_MAX_CYCLES = 40,
    parameter logic [31:0] EXC_VECTOR     = 32'h00000020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        div_start_i,
    input  logic        div_ready_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_cancel_o,
    output logic        div_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic        o_dbg_state
);

    localparam logic [31:0] EXC_ERET    = 32'h0000000e;
    localparam logic [5:0]  LAST_WAIT   = 6'(DIV_MAX_CYCLES - 1);
    localparam logic [5:0]  STALL_MEM   = 6'b011111;
    localparam logic [5:0]  STALL_EX    = 6'b001111;
    localparam logic [5:0]  STALL_ID    = 6'b000111;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_DIV_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_wait_cnt;
    logic        r_div_timeout;
    logic [31:0] r_stall_cnt;

    logic        w_exc;
    logic        w_div_hold;
    logic        w_timeout;

    // Next state, request decode and all combinational outputs
    always_comb begin
        w_state_next = r_state;
        w_exc        = (excepttype_i != 32'd0);
        w_div_hold   = 1'b0;
        w_timeout    = 1'b0;
        stall        = 6'b000000;
        flush        = 1'b0;
        new_pc       = 32'd0;
        div_cancel_o = 1'b0;

        // While rst is low every combinational output is forced to zero.
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    w_div_hold = div_start_i;
                    if (div_start_i && !w_exc) begin
                        w_state_next = ST_DIV_WAIT;
                    end
                    // A divide issued alongside an exception is killed at once.
                    if (div_start_i && w_exc) begin
                        div_cancel_o = 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    w_div_hold = !div_ready_i;
                    w_timeout  = !div_ready_i && (r_wait_cnt == LAST_WAIT);
                    if (div_ready_i || w_exc || w_timeout) begin
                        w_state_next = ST_RUN;
                    end
                    if (w_exc || w_timeout) begin
                        div_cancel_o = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase

            if (w_exc) begin
                stall  = 6'b000000;
                flush  = 1'b1;
                new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else if (stallreq_from_mem) begin
                stall = STALL_MEM;
            end else if (w_div_hold || stallreq_from_ex) begin
                stall = STALL_EX;
            end else if (stallreq_from_id) begin
                stall = STALL_ID;
            end else begin
                stall = 6'b000000;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Divide wait counter: cleared on entry, counts every DIV_WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 6'd0;
        end else if (r_state == ST_RUN) begin
            r_wait_cnt <= 6'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 6'd1;
        end
    end

    // Sticky timeout flag, set the edge after a wait runs out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_div_timeout <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
        end else if (stall[0] && (r_stall_cnt != 32'hFFFFFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign div_timeout_o = r_div_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign o_dbg_state   = (r_state == ST_DIV_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vectors, a behavioural model of the
// stall/flush/divide rules, a per-cycle compare process and literal checks.
module tb_pipe_ctrl;

    localparam int DIV_MAX = 40;

    logic        clk;
    logic        rst;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic        div_start_i;
    logic        div_ready_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_cancel_o;
    logic        div_timeout_o;
    logic [31:0] stall_cnt_o;
    logic        o_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl #(.DIV_MAX_CYCLES(DIV_MAX), .EXC_VECTOR(32'h00000020)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .div_start_i       (div_start_i),
        .div_ready_i       (div_ready_i),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .div_cancel_o      (div_cancel_o),
        .div_timeout_o     (div_timeout_o),
        .stall_cnt_o       (stall_cnt_o),
        .o_dbg_state       (o_dbg_state)
    );

    // Clock: starts high so rising edges fall on multiples of 10 ns
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic        m_busy;      // a divide is outstanding
    int          m_elapsed;   // wait cycles already spent on it
    logic        m_tmo;
    logic [31:0] m_cnt;

    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_cancel;
    logic        e_exc;
    logic        e_out_of_time;

    always_comb begin
        e_stall       = 6'd0;
        e_flush       = 1'b0;
        e_pc          = 32'd0;
        e_cancel      = 1'b0;
        e_exc         = (excepttype_i != 32'd0);
        e_out_of_time = m_busy && !div_ready_i && (m_elapsed == DIV_MAX - 1);
        if (rst) begin
            if (e_exc) begin
                e_flush = 1'b1;
                e_pc    = (excepttype_i == 32'h0000000e) ? cp0_epc_i : 32'h00000020;
            end else if (stallreq_from_mem) begin
                e_stall = 6'b011111;
            end else if (stallreq_from_ex || (m_busy ? !div_ready_i : div_start_i)) begin
                e_stall = 6'b001111;
            end else if (stallreq_from_id) begin
                e_stall = 6'b000111;
            end
            e_cancel = (m_busy && (e_exc || e_out_of_time)) || (!m_busy && div_start_i && e_exc);
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy    <= 1'b0;
            m_elapsed <= 0;
            m_tmo     <= 1'b0;
            m_cnt     <= 32'd0;
        end else begin
            if (e_stall[0] && m_cnt != 32'hFFFFFFFF) m_cnt <= m_cnt + 32'd1;
            if (e_out_of_time) m_tmo <= 1'b1;
            if (m_busy) begin
                if (div_ready_i || e_exc || m_elapsed == DIV_MAX - 1) m_busy <= 1'b0;
                else m_elapsed <= m_elapsed + 1;
            end else if (div_start_i && !e_exc) begin
                m_busy    <= 1'b1;
                m_elapsed <= 0;
            end
        end
    end

    // Per-cycle compare, sampled 1 ns after the falling edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("stall", {26'd0, stall}, {26'd0, e_stall});
            chk("flush", {31'd0, flush}, {31'd0, e_flush});
            chk("new_pc", new_pc, e_pc);
            chk("div_cancel", {31'd0, div_cancel_o}, {31'd0, e_cancel});
            chk("div_timeout", {31'd0, div_timeout_o}, {31'd0, m_tmo});
            chk("stall_cnt", stall_cnt_o, m_cnt);
            chk("div_wait_state", {31'd0, o_dbg_state}, {31'd0, m_busy});
        end
    end

    // Issue a divide; ready_at is the 1-based cycle (start cycle = 1) in
    // which div_ready_i rises, 0 for never.  Returns the EX-held cycle count.
    task automatic run_div(input int ready_at, output int held, output int cancel_at);
        held      = 0;
        cancel_at = 0;
        div_start_i = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            div_ready_i = (n == ready_at);
            #4;
            if (div_cancel_o) cancel_at = n;
            if (stall != 6'b001111) break;
            held++;
            tick();
            div_start_i = 1'b0;
        end
        div_start_i = 1'b0;
    endtask

    int held;
    int cancel_at;
    int busy_cycles;

    initial begin
        rst = 1'b0;
        stallreq_from_id = 0; stallreq_from_ex = 0; stallreq_from_mem = 0;
        div_start_i = 0; div_ready_i = 0; excepttype_i = 0; cp0_epc_i = 0;

        // Reset with random inputs
        repeat (18) begin
            tick();
            stallreq_from_id  = 1'($urandom_range(0, 1));
            stallreq_from_ex  = 1'($urandom_range(0, 1));
            stallreq_from_mem = 1'($urandom_range(0, 1));
            div_start_i       = 1'($urandom_range(0, 1));
            div_ready_i       = 1'($urandom_range(0, 1));
            excepttype_i      = $urandom;
            cp0_epc_i         = $urandom;
        end
        #3;
        chk("reset_stall", {26'd0, stall}, 32'd0);
        chk("reset_new_pc", new_pc, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        tick();
        stallreq_from_id = 0; stallreq_from_ex = 0; stallreq_from_mem = 0;
        div_start_i = 0; div_ready_i = 0; excepttype_i = 0; cp0_epc_i = 0;
        #4 rst = 1'b1;            // 195 ns
        tick();
        #4;
        chk("first_edge_stall", {26'd0, stall}, 32'd0);
        chk("first_edge_cnt", stall_cnt_o, 32'd0);
        tick();

        // Priority ladder
        stallreq_from_id = 1;
        #4 chk("prio_id", {26'd0, stall}, 32'h07);
        tick();
        stallreq_from_ex = 1;
        #4 chk("prio_ex", {26'd0, stall}, 32'h0f);
        tick();
        stallreq_from_mem = 1;
        #4 chk("prio_mem", {26'd0, stall}, 32'h1f);
        tick();
        stallreq_from_id = 0; stallreq_from_ex = 0; stallreq_from_mem = 0;
        #4 chk("prio_cnt", stall_cnt_o, 32'd3);
        tick();

        // Divide completing normally
        run_div(7, held, cancel_at);
        chk("div_held", held, 32'd6);
        chk("div_no_cancel", cancel_at, 32'd0);
        tick();
        div_ready_i = 0;
        #4;
        chk("div_back_run", {31'd0, o_dbg_state}, 32'd0);
        chk("div_no_timeout", {31'd0, div_timeout_o}, 32'd0);
        tick();

        // Divide timing out
        run_div(0, held, cancel_at);
        chk("tmo_held", held, 32'd41);
        chk("tmo_cancel_cycle", cancel_at, 32'd41);
        chk("tmo_flag_next", {31'd0, div_timeout_o}, 32'd1);
        tick();
        tick();
        #4 chk("tmo_sticky", {31'd0, div_timeout_o}, 32'd1);
        tick();

        // MEM stalls inside a wait still consume wait cycles
        div_start_i = 1;
        tick();
        div_start_i = 0;
        busy_cycles = 0;
        for (int n = 1; n <= 60; n++) begin
            stallreq_from_mem = (n >= 3 && n <= 6);
            #4;
            if (!o_dbg_state) break;
            busy_cycles++;
            tick();
        end
        chk("mem_wait_len", busy_cycles, 32'd40);
        stallreq_from_mem = 0;
        tick();

        // Exception during DIV_WAIT
        div_start_i = 1;
        tick();
        div_start_i = 0;
        tick();
        tick();
        excepttype_i = 32'h00000008;
        #4;
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_pc", new_pc, 32'h00000020);
        chk("exc_cancel", {31'd0, div_cancel_o}, 32'd1);
        chk("exc_stall", {26'd0, stall}, 32'd0);
        tick();
        excepttype_i = 0;
        #4 chk("exc_back_run", {31'd0, o_dbg_state}, 32'd0);
        tick();

        // eret
        excepttype_i = 32'h0000000e;
        cp0_epc_i    = 32'h00001234;
        #4;
        chk("eret_pc", new_pc, 32'h00001234);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        tick();
        excepttype_i = 0; cp0_epc_i = 0;

        // Divide start coinciding with an exception
        div_start_i = 1; excepttype_i = 32'h00000004;
        #4;
        chk("simul_cancel", {31'd0, div_cancel_o}, 32'd1);
        chk("simul_pc", new_pc, 32'h00000020);
        tick();
        div_start_i = 0; excepttype_i = 0;
        #4 chk("simul_stay_run", {31'd0, o_dbg_state}, 32'd0);
        tick();

        // Saturation, then asynchronous reset mid-cycle
        force dut.r_stall_cnt = 32'hFFFFFFFE;
        #1 release dut.r_stall_cnt;
        m_cnt = 32'hFFFFFFFE;
        tick();
        stallreq_from_id = 1;
        tick();
        tick();
        tick();
        #4 chk("sat_cnt", stall_cnt_o, 32'hFFFFFFFF);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("async_cnt", stall_cnt_o, 32'd0);
        chk("async_stall", {26'd0, stall}, 32'd0);
        chk("async_timeout", {31'd0, div_timeout_o}, 32'd0);
        #4 rst = 1'b1;
        tick();
        stallreq_from_id = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
